dmem_axi_master: RTL and testbench

Data-memory bus master for the CPU's MEM stage. Consumes the decoded load/store request (memread, memwrite, address, store data, funct3) and executes it as a single-beat AXI4 transaction on the data port. Stalls the pipeline until the response returns, then returns sign- or zero-extended load data. Requests are issued one at a time, with no outstanding-transaction overlap.

---
 rtl/dmem_axi_master.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_axi_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_axi_master
//  Purpose  : MEM-stage load/store master, one single-beat AXI4 access at a time
//  Revision : 1.0  initial release
// ============================================================================
module dmem_axi_master #(
   parameter logic [3:0] MASTER_ID = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        resp_err,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   localparam logic [3:0] c_len_single = 4'd0;
   localparam logic [2:0] c_size_word  = 3'b010;
   localparam logic [1:0] c_burst_incr = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q, rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        w_latch;
   logic [31:0] w_store_data;
   logic [3:0]  w_store_strb;
   logic [7:0]  w_lbyte;
   logic [15:0] w_lhalf;
   logic [31:0] w_load_ext;
   logic        w_unused;

   // Stores replicate the datum across the bus so the strobe alone picks the lanes.
   always_comb begin
      w_store_data = wdata;
      w_store_strb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            w_store_data = {4{wdata[7:0]}};
            w_store_strb = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            w_store_data = {2{wdata[15:0]}};
            w_store_strb = 4'b0011 << {addr[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_lbyte = RDATA[7:0];
      case (off_q)
         2'd1:    w_lbyte = RDATA[15:8];
         2'd2:    w_lbyte = RDATA[23:16];
         2'd3:    w_lbyte = RDATA[31:24];
         default: w_lbyte = RDATA[7:0];
      endcase
      w_lhalf = off_q[1] ? RDATA[31:16] : RDATA[15:0];
      case (funct3_q[1:0])
         2'b00:   w_load_ext = {{24{w_lbyte[7] & ~funct3_q[2]}}, w_lbyte};
         2'b01:   w_load_ext = {{16{w_lhalf[15] & ~funct3_q[2]}}, w_lhalf};
         default: w_load_ext = RDATA;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      w_latch    = 1'b0;
      rdata_d    = rdata_q;
      resp_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (memread) begin
               state_d = S_AR;
               w_latch = 1'b1;
            end else if (memwrite) begin
               state_d = S_AW;
               w_latch = 1'b1;
            end
         end
         S_AR: if (ARREADY) state_d = S_R;
         S_R: begin
            if (RVALID) begin
               state_d    = S_DONE;
               rdata_d    = w_load_ext;
               resp_err_d = (RRESP != 2'b00);
            end
         end
         S_AW: if (AWREADY) state_d = S_W;
         S_W:  if (WREADY) state_d = S_B;
         S_B: begin
            if (BVALID) begin
               state_d    = S_DONE;
               resp_err_d = (BRESP != 2'b00);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         resp_err_q <= resp_err_d;
         if (w_latch) begin
            addr_q   <= addr[31:2];
            off_q    <= addr[1:0];
            funct3_q <= funct3;
            wdata_q  <= w_store_data;
            wstrb_q  <= w_store_strb;
         end
      end
   end

   assign stall    = ((state_q == S_IDLE) && (memread | memwrite)) ||
                     ((state_q != S_IDLE) && (state_q != S_DONE));
   assign rdata    = rdata_q;
   assign resp_err = resp_err_q;

   assign ARID    = MASTER_ID;
   assign ARADDR  = {addr_q, 2'b00};
   assign ARLEN   = c_len_single;
   assign ARSIZE  = c_size_word;
   assign ARBURST = c_burst_incr;
   assign ARVALID = (state_q == S_AR);
   assign RREADY  = (state_q == S_R);

   assign AWID    = MASTER_ID;
   assign AWADDR  = {addr_q, 2'b00};
   assign AWLEN   = c_len_single;
   assign AWSIZE  = c_size_word;
   assign AWBURST = c_burst_incr;
   assign AWVALID = (state_q == S_AW);
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WLAST   = (state_q == S_W);
   assign WVALID  = (state_q == S_W);
   assign BREADY  = (state_q == S_B);

   // Single outstanding transaction, so IDs and RLAST carry no information.
   assign w_unused = ^{RID, RLAST, BID};

endmodule
`default_nettype wire

// File: tb/tb_dmem_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_axi_master
//  Purpose  : self-checking bench for dmem_axi_master with a behavioural slave
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_axi_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread, memwrite;
   logic [31:0] addr, wdata;
   logic [2:0]  funct3;
   logic        stall, resp_err;
   logic [31:0] rdata;
   logic [3:0]  ARID, ARLEN, AWID, AWLEN;
   logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic [3:0]  RID, BID, WSTRB;

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration
   int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
   logic [31:0] slv_rdata;
   logic [1:0]  slv_resp;

   // per-transaction observations
   int          o_stall_cyc, o_err_cyc, o_first_valid, o_proto;
   int          o_ar_cyc, o_aw_cyc, o_ar_hs, o_aw_hs, o_w_hs, o_b_hs, o_r_hs;
   logic        o_first_err, o_timeout, o_wlast;
   logic [31:0] o_rdata, o_araddr, o_awaddr, o_wdata;
   logic [3:0]  o_wstrb;
   logic [12:0] o_ar_attr, o_aw_attr;
   logic [31:0] model_rdata;

   localparam logic [12:0] c_attr = {4'd1, 4'd0, 3'b010, 2'b01};

   dmem_axi_master #(.MASTER_ID(4'd1)) dut (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
      .addr(addr), .wdata(wdata), .funct3(funct3),
      .stall(stall), .rdata(rdata), .resp_err(resp_err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 clk = ~clk;

   // Reference behaviour expressed as byte/halfword arithmetic on the bus word.
   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
      logic [31:0] v;
      case (f3)
         3'b000, 3'b100: begin
            v = (d >> (8 * (a % 4))) % 256;
            if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'b001, 3'b101: begin
            v = (d >> (16 * ((a / 2) % 2))) % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      case (f3)
         3'b000:  v = 32'd1 << (a % 4);
         3'b001:  v = 32'd3 << (2 * ((a / 2) % 2));
         default: v = 32'd15;
      endcase
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return (d % 256) * 32'h0101_0101;
         3'b001:  return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   // Presents one request and plays the slave; returns in the cycle after DONE.
   task automatic run_txn(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
      int  cyc, arc, rc, awc, wc, bc;
      bit  done;
      memread = rd; memwrite = !rd; funct3 = f3; addr = a; wdata = d;
      o_stall_cyc = 0; o_err_cyc = 0; o_first_valid = -1; o_proto = 0;
      o_ar_cyc = 0; o_aw_cyc = 0; o_ar_hs = 0; o_aw_hs = 0; o_w_hs = 0; o_b_hs = 0;
      o_r_hs = 0; o_first_err = 1'b0; o_timeout = 1'b0; o_wlast = 1'b0;
      o_rdata = '0; o_araddr = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0;
      o_ar_attr = '0; o_aw_attr = '0;
      arc = 0; rc = 0; awc = 0; wc = 0; bc = 0; cyc = 0; done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         if (cyc == 0) o_first_err = resp_err;
         if (stall) o_stall_cyc++;
         if (resp_err) o_err_cyc++;
         if ((ARVALID || RREADY) && (AWVALID || WVALID || BREADY)) o_proto++;
         if (ARVALID) begin
            if (o_ar_cyc == 0) begin
               o_araddr = ARADDR; o_ar_attr = {ARID, ARLEN, ARSIZE, ARBURST};
               o_first_valid = cyc;
            end else if (ARADDR !== o_araddr) o_proto++;
            o_ar_cyc++;
         end
         if (AWVALID) begin
            if (o_aw_cyc == 0) begin
               o_awaddr = AWADDR; o_aw_attr = {AWID, AWLEN, AWSIZE, AWBURST};
               o_first_valid = cyc;
            end else if (AWADDR !== o_awaddr) o_proto++;
            o_aw_cyc++;
         end
         if (WVALID) begin
            if (wc == 0) begin
               o_wdata = WDATA; o_wstrb = WSTRB; o_wlast = WLAST;
            end else if (WDATA !== o_wdata || WSTRB !== o_wstrb) o_proto++;
         end
         if (RREADY && o_ar_hs == 0) o_proto++;
         if (WVALID && o_aw_hs == 0) o_proto++;
         if (BREADY && o_w_hs == 0) o_proto++;
         if (!stall && (memread || memwrite)) begin
            done = 1;
            o_rdata = rdata;
            if (ARVALID || RREADY || AWVALID || WVALID || BREADY) o_proto++;
         end
         ARREADY = ARVALID && (arc == ar_dly);  if (ARVALID) arc++;
         RVALID  = RREADY  && (rc == r_dly);    if (RREADY)  rc++;
         AWREADY = AWVALID && (awc == aw_dly);  if (AWVALID) awc++;
         WREADY  = WVALID  && (wc == w_dly);    if (WVALID)  wc++;
         BVALID  = BREADY  && (bc == b_dly);    if (BREADY)  bc++;
         RDATA   = RVALID ? slv_rdata : $urandom;
         RRESP   = RVALID ? slv_resp : 2'b11;
         BRESP   = BVALID ? slv_resp : 2'b11;
         RID     = 4'($urandom_range(0, 15));
         BID     = 4'($urandom_range(0, 15));
         RLAST   = 1'b1;
         if (ARVALID && ARREADY) o_ar_hs++;
         if (RVALID && RREADY)   o_r_hs++;
         if (AWVALID && AWREADY) o_aw_hs++;
         if (WVALID && WREADY)   o_w_hs++;
         if (BVALID && BREADY)   o_b_hs++;
         @(posedge clk);
         #1;
         cyc++;
      end
      memread = 1'b0; memwrite = 1'b0;
      if (!done) begin
         o_timeout = 1'b1;
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
      end
   endtask

   task automatic set_slave(input int ar, input int r, input int aw, input int w, input int b,
                            input logic [31:0] rd, input logic [1:0] resp);
      ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
      slv_rdata = rd; slv_resp = resp;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0; funct3 = '0;
      ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      RDATA = '0; RRESP = '0; RID = '0; RLAST = 1'b0; BRESP = '0; BID = '0;
      #1;
      n_checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin n_fail++; $display("FAIL reset_handshake: got %b want 00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY}); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
      n_checks++; if ({ARADDR, AWADDR, WDATA, WSTRB, WLAST} !== 101'h0) begin n_fail++; $display("FAIL reset_payload: araddr %h awaddr %h wdata %h wstrb %b want all 0", ARADDR, AWADDR, WDATA, WSTRB); end
      memread = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %b want 1", stall); end
      memread = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_lw_wait();
      set_slave(2, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
      run_txn(1'b1, 3'b010, 32'h0001_0004, 32'h0);
      model_rdata = 32'hDEAD_BEEF;
      n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL lw_timeout: no DONE within budget"); end
      n_checks++; if (o_araddr !== 32'h0001_0004) begin n_fail++; $display("FAIL lw_araddr: got %h want 00010004", o_araddr); end
      n_checks++; if (o_ar_cyc != 3) begin n_fail++; $display("FAIL lw_arvalid_cycles: got %0d want 3", o_ar_cyc); end
      n_checks++; if (o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
      n_checks++; if (o_stall_cyc != 5) begin n_fail++; $display("FAIL lw_stall: got %0d want 5", o_stall_cyc); end
      n_checks++; if (o_ar_attr !== c_attr) begin n_fail++; $display("FAIL lw_ar_attr: got %h want %h", o_ar_attr, c_attr); end
      n_checks++; if (o_proto != 0) begin n_fail++; $display("FAIL lw_protocol: got %0d violations want 0", o_proto); end
   endtask

   task automatic test_lb_lbu();
      set_slave(0, 0, 0, 0, 0, 32'h80FF_FFFF, 2'b00);
      run_txn(1'b1, 3'b000, 32'h0001_0003, 32'h0);
      n_checks++; if (o_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      n_checks++; if (o_stall_cyc != 3) begin n_fail++; $display("FAIL lb_stall: got %0d want 3", o_stall_cyc); end
      run_txn(1'b1, 3'b100, 32'h0001_0003, 32'h0);
      model_rdata = 32'h0000_0080;
      n_checks++; if (o_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", o_rdata); end
      n_checks++; if (o_araddr !== 32'h0001_0000) begin n_fail++; $display("FAIL lbu_araddr: got %h want 00010000", o_araddr); end
   endtask

   task automatic test_sh();
      set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00);
      run_txn(1'b0, 3'b001, 32'h0002_0002, 32'h1234_ABCD);
      n_checks++; if (o_awaddr !== 32'h0002_0000) begin n_fail++; $display("FAIL sh_awaddr: got %h want 00020000", o_awaddr); end
      n_checks++; if (o_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", o_wstrb); end
      n_checks++; if (o_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
      n_checks++; if (o_wlast !== 1'b1) begin n_fail++; $display("FAIL sh_wlast: got %b want 1", o_wlast); end
      n_checks++; if (o_stall_cyc != 4) begin n_fail++; $display("FAIL sh_stall: got %0d want 4", o_stall_cyc); end
      n_checks++; if (o_aw_attr !== c_attr) begin n_fail++; $display("FAIL sh_aw_attr: got %h want %h", o_aw_attr, c_attr); end
      n_checks++; if (o_proto != 0) begin n_fail++; $display("FAIL sh_protocol: got %0d violations want 0", o_proto); end
      n_checks++; if (o_rdata !== model_rdata) begin n_fail++; $display("FAIL sh_rdata_hold: got %h want %h", o_rdata, model_rdata); end
   endtask

   task automatic test_back_to_back();
      set_slave(0, 0, 0, 0, 3, 32'h0, 2'b00);
      run_txn(1'b0, 3'b010, 32'h0000_0100, 32'hCAFE_F00D);
      n_checks++; if (o_stall_cyc != 7) begin n_fail++; $display("FAIL b2b_store_stall: got %0d want 7", o_stall_cyc); end
      n_checks++; if ({o_aw_hs, o_w_hs, o_b_hs, o_ar_cyc} != {32'd1, 32'd1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL b2b_store_counts: aw %0d w %0d b %0d ar %0d want 1 1 1 0", o_aw_hs, o_w_hs, o_b_hs, o_ar_cyc); end
      set_slave(0, 0, 0, 0, 0, 32'h0BAD_F00D, 2'b00);
      run_txn(1'b1, 3'b010, 32'h0000_0100, 32'h0);
      model_rdata = 32'h0BAD_F00D;
      n_checks++; if (o_first_valid != 1) begin n_fail++; $display("FAIL b2b_arvalid_rise: got cycle %0d want 1 after IDLE", o_first_valid); end
      n_checks++; if ({o_ar_hs, o_r_hs, o_aw_cyc} != {32'd1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL b2b_load_counts: ar %0d r %0d aw %0d want 1 1 0", o_ar_hs, o_r_hs, o_aw_cyc); end
      n_checks++; if (o_proto != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d violations want 0", o_proto); end
      n_checks++; if (o_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_rdata: got %h want 0badf00d", o_rdata); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      memwrite = 1'b1; funct3 = 3'b010; addr = 32'h0003_0008; wdata = 32'h55AA_55AA;
      AWREADY = 1'b1; WREADY = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (WVALID) seen = 1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_w: WVALID never seen within 10 cycles"); end
      rst = 1'b1; memwrite = 1'b0; AWREADY = 1'b0;
      #1;
      n_checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, WLAST} !== 6'b0) begin n_fail++; $display("FAIL rstmid_handshake: got %b want 000000", {ARVALID, RREADY, AWVALID, WVALID, BREADY, WLAST}); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall); end
      n_checks++; if ({AWADDR, WDATA, WSTRB} !== 68'h0) begin n_fail++; $display("FAIL rstmid_payload: awaddr %h wdata %h wstrb %b want 0", AWADDR, WDATA, WSTRB); end
      n_checks++; if ({rdata, resp_err} !== 33'h0) begin n_fail++; $display("FAIL rstmid_rdata: rdata %h resp_err %b want 0", rdata, resp_err); end
      @(posedge clk);
      #1 rst = 1'b0;
      set_slave(0, 1, 0, 0, 0, 32'h1357_9BDF, 2'b00);
      run_txn(1'b1, 3'b010, 32'h0003_0008, 32'h0);
      model_rdata = 32'h1357_9BDF;
      n_checks++; if (o_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rstmid_lw_rdata: got %h want 13579bdf", o_rdata); end
      n_checks++; if (o_stall_cyc != 4) begin n_fail++; $display("FAIL rstmid_lw_stall: got %0d want 4", o_stall_cyc); end
   endtask

   task automatic test_bresp_err();
      set_slave(0, 0, 0, 0, 0, 32'h0, 2'b10);
      run_txn(1'b0, 3'b010, 32'h0000_0200, 32'h0F0F_0F0F);
      n_checks++; if (o_err_cyc != 1) begin n_fail++; $display("FAIL bresp_err_cycles: got %0d want 1", o_err_cyc); end
      n_checks++; if (o_stall_cyc != 4) begin n_fail++; $display("FAIL bresp_stall: got %0d want 4", o_stall_cyc); end
      set_slave(0, 0, 0, 0, 0, 32'h2468_ACE0, 2'b00);
      run_txn(1'b1, 3'b101, 32'h0000_0202, 32'h0);
      model_rdata = 32'h0000_2468;
      n_checks++; if (o_first_err !== 1'b0) begin n_fail++; $display("FAIL bresp_err_after_done: got %b want 0", o_first_err); end
      n_checks++; if ({o_rdata, 32'(o_err_cyc)} !== {32'h0000_2468, 32'd0}) begin n_fail++; $display("FAIL bresp_next_lhu: rdata %h err %0d want 00002468 0", o_rdata, o_err_cyc); end
   endtask

   task automatic test_random();
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_rd;
      logic [2:0]  ld_codes [5];
      int          exp_stall;
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int t = 0; t < 40; t++) begin
         rd = 1'($urandom_range(0, 1));
         f3 = rd ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         a = $urandom; d = $urandom;
         set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         exp_stall = rd ? 3 + ar_dly + r_dly : 4 + aw_dly + w_dly + b_dly;
         if (rd) model_rdata = m_load(f3, a, slv_rdata);
         exp_rd = model_rdata;
         run_txn(rd, f3, a, d);
         n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: no DONE within budget", t); end
         n_checks++; if (o_stall_cyc != exp_stall) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d want %0d", t, o_stall_cyc, exp_stall); end
         n_checks++; if (o_err_cyc != ((slv_resp != 2'b00) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_resp_err: got %0d cycles resp %b", t, o_err_cyc, slv_resp); end
         n_checks++; if (o_proto != 0 || o_first_valid != 1) begin n_fail++; $display("FAIL rnd%0d_protocol: violations %0d first valid %0d want 0 1", t, o_proto, o_first_valid); end
         n_checks++; if (o_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h (f3 %b addr %h)", t, o_rdata, exp_rd, f3, a); end
         if (rd) begin
            n_checks++; if (o_araddr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd%0d_araddr: got %h want %h", t, o_araddr, {a[31:2], 2'b00}); end
         end else begin
            n_checks++; if (o_awaddr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd%0d_awaddr: got %h want %h", t, o_awaddr, {a[31:2], 2'b00}); end
            n_checks++; if ({o_wstrb, o_wdata} !== {m_strb(f3, a), m_wdata(f3, d)}) begin n_fail++; $display("FAIL rnd%0d_wbeat: got %b %h want %b %h", t, o_wstrb, o_wdata, m_strb(f3, a), m_wdata(f3, d)); end
         end
      end
   endtask

   initial begin
      model_rdata = '0;
      test_reset();
      test_lw_wait();
      test_lb_lbu();
      test_sh();
      test_back_to_back();
      test_reset_mid();
      test_bresp_err();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
